// File: rtl/lcd_seq_engine.sv
// lcd_seq_engine: panel reset pulse, ROM-scripted 8080 bus bring-up, then valid/ready pixel streaming.
// Ports: clk/rst (sync, active-high); rom_addr/rom_data script ROM ({op, payload}, 1-cycle latency);
// seq_start/start_addr restart a script segment from STREAM; pix_data/pix_valid/pix_ready pixel input;
// lcd_data/lcd_rs/lcd_wr/lcd_rd/lcd_cs/lcd_rst panel pins; busy/init_done/seq_err status.
module lcd_seq_engine #(
    parameter int DATA_W      = 16,
    parameter int ROM_AW      = 8,
    parameter int CLK_PER_MS  = 100000,
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2,
    parameter int RST_LOW_MS  = 10,
    parameter int RST_WAIT_MS = 120
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DATA_W+1:0] rom_data,
    input  logic              seq_start,
    input  logic [ROM_AW-1:0] start_addr,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [DATA_W-1:0] lcd_data,
    output logic              lcd_rs,
    output logic              lcd_wr,
    output logic              lcd_rd,
    output logic              lcd_cs,
    output logic              lcd_rst,
    output logic              busy,
    output logic              init_done,
    output logic              seq_err
);
    localparam int WR_MAX  = WR_LOW_CYC > WR_HIGH_CYC ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int CNT_MAX = CLK_PER_MS > WR_MAX ? CLK_PER_MS : WR_MAX;
    localparam int PW      = $clog2(CNT_MAX + 1);
    localparam int RST_MAX = RST_LOW_MS > RST_WAIT_MS ? RST_LOW_MS : RST_WAIT_MS;
    localparam int MS_MAX  = RST_MAX > 255 ? RST_MAX : 255;
    localparam int MW      = $clog2(MS_MAX + 1);
    localparam logic [1:0] OP_DELAY = 2'd2;
    localparam logic [1:0] OP_END   = 2'd3;

    typedef enum logic [2:0] {RST_LO, RST_WAIT, FETCH, DECODE, WR_LO, WR_HI, DELAY, STREAM} state_t;

    state_t            state;
    logic [PW-1:0]     pre;
    logic [MW-1:0]     ms;
    logic [MW-1:0]     tgt;
    logic [7:0]        dly;
    logic              pix;
    logic [1:0]        op;
    logic [DATA_W-1:0] payload;
    logic              tick;
    logic              ms_done;
    logic              wr_done;
    logic              adv;

    // pre doubles as the ms prescaler and the write-phase counter; it is zero on every state entry.
    // adv marks completion of a non-END script entry, moving to the next address or overflowing into STREAM.
    always_comb begin
        op      = rom_data[DATA_W+1:DATA_W];
        payload = rom_data[DATA_W-1:0];
        tgt     = state == RST_LO ? MW'(RST_LOW_MS) : state == RST_WAIT ? MW'(RST_WAIT_MS) : MW'(dly);
        tick    = pre == PW'(CLK_PER_MS - 1);
        ms_done = tick && ms + MW'(1) == tgt;
        wr_done = pre == PW'(state == WR_LO ? WR_LOW_CYC - 1 : WR_HIGH_CYC - 1);
        adv     = (state == DECODE && op == OP_DELAY && payload[7:0] == 8'd0) ||
                  (state == DELAY && ms_done) || (state == WR_HI && wr_done && !pix);
    end

    always_ff @(posedge clk) begin
        lcd_rd <= 1'b1;
        if (rst) begin
            state     <= RST_LO;
            pre       <= '0;
            ms        <= '0;
            dly       <= '0;
            pix       <= 1'b0;
            rom_addr  <= '0;
            lcd_data  <= '0;
            lcd_rs    <= 1'b0;
            lcd_wr    <= 1'b1;
            lcd_cs    <= 1'b1;
            lcd_rst   <= 1'b0;
            busy      <= 1'b1;
            init_done <= 1'b0;
            seq_err   <= 1'b0;
            pix_ready <= 1'b0;
        end else begin
            case (state)
                RST_LO, RST_WAIT, DELAY: begin
                    pre <= tick ? '0 : pre + PW'(1);
                    if (tick) ms <= ms_done ? '0 : ms + MW'(1);
                    if (ms_done && state == RST_LO) begin
                        lcd_rst <= 1'b1;
                        state   <= RST_WAIT;
                    end
                    if (ms_done && state == RST_WAIT) state <= FETCH;
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    if (op == OP_END) begin
                        state     <= STREAM;
                        init_done <= 1'b1;
                        busy      <= 1'b0;
                        lcd_cs    <= 1'b1;
                        pix_ready <= 1'b1;
                    end else if (op == OP_DELAY) begin
                        state <= DELAY;
                        dly   <= payload[7:0];
                    end else begin
                        state    <= WR_LO;
                        lcd_data <= payload;
                        lcd_rs   <= op[0];
                        lcd_wr   <= 1'b0;
                        lcd_cs   <= 1'b0;
                        pix      <= 1'b0;
                    end
                end
                WR_LO, WR_HI: begin
                    pre <= wr_done ? '0 : pre + PW'(1);
                    if (wr_done && state == WR_LO) begin
                        state  <= WR_HI;
                        lcd_wr <= 1'b1;
                    end
                    if (wr_done && state == WR_HI && pix) begin
                        state     <= STREAM;
                        pix_ready <= 1'b1;
                    end
                end
                STREAM: begin
                    // A script restart outranks a pixel offered in the same cycle.
                    if (seq_start) begin
                        state     <= FETCH;
                        rom_addr  <= start_addr;
                        busy      <= 1'b1;
                        pix_ready <= 1'b0;
                    end else if (pix_valid) begin
                        state     <= WR_LO;
                        lcd_data  <= pix_data;
                        lcd_rs    <= 1'b1;
                        lcd_wr    <= 1'b0;
                        lcd_cs    <= 1'b0;
                        pix_ready <= 1'b0;
                        pix       <= 1'b1;
                    end
                end
            endcase
            // The last ROM word never wraps: finishing it without END ends the script with an error.
            if (adv) begin
                if (&rom_addr) begin
                    state     <= STREAM;
                    seq_err   <= 1'b1;
                    init_done <= 1'b1;
                    busy      <= 1'b0;
                    lcd_cs    <= 1'b1;
                    pix_ready <= 1'b1;
                end else begin
                    state    <= FETCH;
                    rom_addr <= rom_addr + ROM_AW'(1);
                end
            end
        end
    end
endmodule
